// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// State encoding, counter width and the address error check.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W = 4;

  function automatic logic is_err(
    input logic [31:0] addr,
    input logic [31:0] depth
  );
    return (addr[1:0] != 2'b00) ||
           ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage load/store bus between CPU and responder.
// master = CPU side, slave = memory side.
interface dmem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        stall_o;

  modport master (
    output req_valid_i, req_we_i,
    output req_addr_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o,
    input  rsp_rdata_o, rsp_err_o,
    input  stall_o
  );

  modport slave (
    input  req_valid_i, req_we_i,
    input  req_addr_i, req_wdata_i,
    output req_ready_o, rsp_valid_o,
    output rsp_rdata_o, rsp_err_o,
    output stall_o
  );
endinterface

// File: rtl/dmem_array.sv
// Word storage: synchronous write, combinational read.
// Contents are deliberately left unreset.
module dmem_array #(
  parameter int DEPTH = 128,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  // Commit a store word on the clock edge
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: one request at a time, fixed
// per-kind latency, single-cycle response pulse and stall.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int RD_LATENCY  = 2,
  parameter int WR_LATENCY  = 1
) (
  input logic             clk_i,
  input logic             rst_i,
  dmem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt, lat;
  logic             we_q;
  logic [31:0]      addr_q, wdata_q;
  logic             sel_we, sel_err;
  logic [31:0]      sel_addr, sel_wdata;
  logic             go_resp, wr_en, accept;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_data, rdata_q;
  logic             err_q;

  // Pick the live request in IDLE, the latched one later
  always_comb begin
    accept    = (state == IDLE) & bus.req_valid_i;
    sel_we    = (state == IDLE) ? bus.req_we_i : we_q;
    sel_addr  = (state == IDLE) ? bus.req_addr_i : addr_q;
    sel_wdata = (state == IDLE) ? bus.req_wdata_i : wdata_q;
    sel_err   = is_err(sel_addr, 32'(DEPTH_WORDS));
    lat       = bus.req_we_i ? CNT_W'(WR_LATENCY)
                             : CNT_W'(RD_LATENCY);
    idx       = sel_addr[IDX_W+1:2];
  end

  // Next state; go_resp marks the edge entering RESP
  always_comb begin
    nxt     = state;
    go_resp = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (lat > CNT_ONE) begin
            nxt = WAIT;
          end else begin
            nxt     = RESP;
            go_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt <= CNT_ONE) begin
          nxt     = RESP;
          go_resp = 1'b1;
        end
      end
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign wr_en = go_resp & sel_we & ~sel_err & rst_i;

  dmem_array #(
    .DEPTH (DEPTH_WORDS),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk_i),
    .we    (wr_en),
    .addr  (idx),
    .wdata (sel_wdata),
    .rdata (rd_data)
  );

  // State, latency counter, request latch, response regs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        we_q    <= bus.req_we_i;
        addr_q  <= bus.req_addr_i;
        wdata_q <= bus.req_wdata_i;
        cnt     <= lat - CNT_ONE;
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_ONE;
      end
      rdata_q <= (go_resp & ~sel_we & ~sel_err)
                 ? rd_data : '0;
      err_q   <= go_resp & sel_err;
    end
  end

  assign bus.req_ready_o = (state == IDLE);
  assign bus.rsp_valid_o = (state == RESP);
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;
  assign bus.stall_o     = (state == WAIT) |
                           ((state == IDLE) & bus.req_valid_i);

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a
// word-array reference model, three latency configs.
module tb_dmem_responder;

  localparam int DEPTH = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_c [int];

  always #5 clk = ~clk;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();
  dmem_responder_if bus_c ();

  dmem_responder #(
    .DEPTH_WORDS (DEPTH), .RD_LATENCY (2), .WR_LATENCY (1)
  ) dut_a (.clk_i (clk), .rst_i (rst_n), .bus (bus_a));

  dmem_responder #(
    .DEPTH_WORDS (DEPTH), .RD_LATENCY (1), .WR_LATENCY (1)
  ) dut_b (.clk_i (clk), .rst_i (rst_n), .bus (bus_b));

  dmem_responder #(
    .DEPTH_WORDS (DEPTH), .RD_LATENCY (3), .WR_LATENCY (4)
  ) dut_c (.clk_i (clk), .rst_i (rst_n), .bus (bus_c));

  function automatic int exp_lat(input int w, input bit we);
    if (w == 0) return we ? 1 : 2;
    if (w == 1) return 1;
    return we ? 4 : 3;
  endfunction

  function automatic bit exp_err(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= DEPTH);
  endfunction

  task automatic drv(input int w, input bit v, input bit we,
                     input logic [31:0] a, input logic [31:0] d);
    case (w)
      0: begin
        bus_a.req_valid_i = v; bus_a.req_we_i = we;
        bus_a.req_addr_i = a;  bus_a.req_wdata_i = d;
      end
      1: begin
        bus_b.req_valid_i = v; bus_b.req_we_i = we;
        bus_b.req_addr_i = a;  bus_b.req_wdata_i = d;
      end
      default: begin
        bus_c.req_valid_i = v; bus_c.req_we_i = we;
        bus_c.req_addr_i = a;  bus_c.req_wdata_i = d;
      end
    endcase
  endtask

  task automatic smp(input int w, output bit rdy, output bit rv,
                     output bit st, output bit e,
                     output logic [31:0] rd);
    case (w)
      0: begin
        rdy = bus_a.req_ready_o; rv = bus_a.rsp_valid_o;
        st = bus_a.stall_o; e = bus_a.rsp_err_o;
        rd = bus_a.rsp_rdata_o;
      end
      1: begin
        rdy = bus_b.req_ready_o; rv = bus_b.rsp_valid_o;
        st = bus_b.stall_o; e = bus_b.rsp_err_o;
        rd = bus_b.rsp_rdata_o;
      end
      default: begin
        rdy = bus_c.req_ready_o; rv = bus_c.rsp_valid_o;
        st = bus_c.stall_o; e = bus_c.rsp_err_o;
        rd = bus_c.rsp_rdata_o;
      end
    endcase
  endtask

  // One request held until its response; returns what was seen
  task automatic txn(input int w, input bit we,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output bit err,
                     output int lat, output bit stall_bad);
    bit rdy, rv, st, e;
    logic [31:0] r;
    bit acc;
    rd = '0; err = 1'b0; lat = -1; stall_bad = 1'b0; acc = 1'b0;
    @(negedge clk);
    drv(w, 1'b1, we, a, d);
    for (int i = 0; i < 20; i++) begin
      #1 smp(w, rdy, rv, st, e, r);
      if (rdy) begin
        if (!st) stall_bad = 1'b1;
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (acc) begin
      for (int n = 1; n <= 40; n++) begin
        @(negedge clk);
        #1 smp(w, rdy, rv, st, e, r);
        if (rv) begin
          lat = n; rd = r; err = e;
          if (st) stall_bad = 1'b1;
          break;
        end
        if (!st) stall_bad = 1'b1;
      end
    end
    drv(w, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    bit rdy, rv, st, e;
    logic [31:0] r;
    rst_n = 1'b0;
    for (int w = 0; w < 3; w++) drv(w, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    for (int w = 0; w < 3; w += 2) begin
      smp(w, rdy, rv, st, e, r);
      checks++;
      if ({rdy, rv, st, e} !== 4'b1000 || r !== 32'h0)
        $display("FAIL reset_outputs dut%0d got rdy/rv/st/err=%b%b%b%b rdata=%h want 1000 rdata=0",
                 w, rdy, rv, st, e, r);
      else passes++;
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_init();
    logic [31:0] rd, d;
    bit err, sb;
    int lat, bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      txn(0, 1'b1, 32'(i * 4), d, rd, err, lat, sb);
      mem_a[i] = d;
      if (err || lat != 1 || sb || rd !== 32'h0) bad++;
    end
    checks++;
    if (bad != 0)
      $display("FAIL init_stores bad_responses got %0d want 0", bad);
    else passes++;
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    bit err, sb;
    int lat;
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, err, lat, sb);
    mem_a[4] = 32'hDEADBEEF;
    checks++;
    if (lat != 1 || err || rd !== 32'h0 || sb)
      $display("FAIL basic_store got lat=%0d err=%b rd=%h sb=%b want lat=1 err=0 rd=0 sb=0",
               lat, err, rd, sb);
    else passes++;
    txn(0, 1'b0, 32'h10, 32'h0, rd, err, lat, sb);
    checks++;
    if (lat != 2 || err || rd !== 32'hDEADBEEF || sb)
      $display("FAIL basic_load got lat=%0d err=%b rd=%h sb=%b want lat=2 err=0 rd=deadbeef sb=0",
               lat, err, rd, sb);
    else passes++;
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    bit err, sb;
    int lat;
    logic [31:0] addrs [4];
    bit wes [4];
    addrs[0] = 32'h13;       wes[0] = 1'b0;
    addrs[1] = 32'h11;       wes[1] = 1'b1;
    addrs[2] = DEPTH * 4;    wes[2] = 1'b0;
    addrs[3] = 32'hFFFFFFFC; wes[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      txn(0, wes[i], addrs[i], 32'h5A5A5A5A, rd, err, lat, sb);
      checks++;
      if (err !== exp_err(addrs[i]) || rd !== 32'h0 ||
          lat != exp_lat(0, wes[i]))
        $display("FAIL err_resp addr=%h got err=%b rd=%h lat=%0d want err=1 rd=0 lat=%0d",
                 addrs[i], err, rd, lat, exp_lat(0, wes[i]));
      else passes++;
    end
    for (int i = 0; i < 2; i++) begin
      txn(0, 1'b0, 32'(i * 16), 32'h0, rd, err, lat, sb);
      checks++;
      if (rd !== mem_a[i * 4] || err)
        $display("FAIL err_no_side_effect word%0d got %h want %h",
                 i * 4, rd, mem_a[i * 4]);
      else passes++;
    end
  endtask

  // Valid held high: loads/stores alternate with no idle gap
  task automatic test_back_to_back();
    bit rdy, rv, st, e, we;
    logic [31:0] r, a, d, exp;
    int cyc, i, last_acc, cur_lat, prev_lat;
    int gap_bad, lat_bad, data_bad, stall_bad, accs, pulses;
    cyc = 0; i = 0; last_acc = -1; prev_lat = 0; cur_lat = 0;
    gap_bad = 0; lat_bad = 0; data_bad = 0; stall_bad = 0;
    accs = 0; pulses = 0;
    a = 32'($urandom_range(0, DEPTH - 1) * 4);
    d = $urandom;
    we = 1'b1; exp = 32'h0; mem_a[a / 4] = d;
    @(negedge clk);
    drv(0, 1'b1, we, a, d);
    while (i < 10 && cyc < 200) begin
      #1 smp(0, rdy, rv, st, e, r);
      if (st === rv) stall_bad++;
      if (rdy) begin
        accs++;
        if (last_acc >= 0 && cyc - last_acc != prev_lat + 1)
          gap_bad++;
        last_acc = cyc;
        cur_lat = exp_lat(0, we);
      end
      if (rv) begin
        pulses++;
        if (cyc - last_acc != cur_lat) lat_bad++;
        if (r !== exp || e) data_bad++;
        prev_lat = cur_lat;
        i++;
        we = ~we;
        if (we) begin
          a = 32'($urandom_range(0, DEPTH - 1) * 4);
          d = $urandom;
          mem_a[a / 4] = d;
          exp = 32'h0;
        end else begin
          exp = mem_a[a / 4];
        end
        if (i < 10) drv(0, 1'b1, we, a, d);
        else drv(0, 1'b0, 1'b0, '0, '0);
      end
      @(negedge clk);
      cyc++;
    end
    drv(0, 1'b0, 1'b0, '0, '0);
    checks++;
    if (accs != 10 || pulses != 10)
      $display("FAIL b2b_counts got acc=%0d pulses=%0d want 10/10",
               accs, pulses);
    else passes++;
    checks++;
    if (gap_bad != 0 || lat_bad != 0)
      $display("FAIL b2b_timing got gap_bad=%0d lat_bad=%0d want 0/0",
               gap_bad, lat_bad);
    else passes++;
    checks++;
    if (data_bad != 0)
      $display("FAIL b2b_data got %0d bad want 0", data_bad);
    else passes++;
    checks++;
    if (stall_bad != 0)
      $display("FAIL b2b_stall got %0d bad cycles want 0", stall_bad);
    else passes++;
  endtask

  task automatic test_lat1();
    logic [31:0] rd;
    bit err, sb;
    int lat;
    txn(1, 1'b1, 32'h0, 32'h1, rd, err, lat, sb);
    checks++;
    if (lat != 1 || err || sb)
      $display("FAIL lat1_store got lat=%0d err=%b sb=%b want 1/0/0",
               lat, err, sb);
    else passes++;
    txn(1, 1'b0, 32'h0, 32'h0, rd, err, lat, sb);
    checks++;
    if (lat != 1 || err || rd !== 32'h1 || sb)
      $display("FAIL lat1_load got lat=%0d err=%b rd=%h want lat=1 rd=1",
               lat, err, rd);
    else passes++;
  endtask

  task automatic test_rand_c();
    logic [31:0] rd, a, d, exp;
    bit err, sb, we, xe;
    int lat;
    for (int i = 0; i < 16; i++) begin
      a = 32'($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 3));
      we = 1'($urandom_range(0, 1));
      if (!we && !mem_c.exists(int'(a / 4)) && a % 4 == 0) we = 1'b1;
      d = $urandom;
      xe = exp_err(a);
      exp = 32'h0;
      if (!we && !xe) exp = mem_c[int'(a / 4)];
      txn(2, we, a, d, rd, err, lat, sb);
      if (we && !xe) mem_c[int'(a / 4)] = d;
      checks++;
      if (rd !== exp || err !== xe || lat != exp_lat(2, we) || sb)
        $display("FAIL rand_c op%0d we=%b a=%h got rd=%h err=%b lat=%0d sb=%b want rd=%h err=%b lat=%0d",
                 i, we, a, rd, err, lat, sb, exp, xe, exp_lat(2, we));
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, r;
    bit err, sb, rdy, rv, st, e;
    int lat, pulses;
    txn(2, 1'b1, 32'h8, 32'h1234, rd, err, lat, sb);
    mem_c[2] = 32'h1234;
    @(negedge clk);
    drv(2, 1'b1, 1'b1, 32'h8, 32'h55);
    @(negedge clk);
    rst_n = 1'b0;
    drv(2, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1 smp(2, rdy, rv, st, e, r);
      if (rv) pulses++;
    end
    checks++;
    if (pulses != 0)
      $display("FAIL reset_mid_no_rsp got %0d pulses want 0", pulses);
    else passes++;
    txn(2, 1'b0, 32'h8, 32'h0, rd, err, lat, sb);
    checks++;
    if (rd !== mem_c[2] || err)
      $display("FAIL reset_mid_data got %h want %h", rd, mem_c[2]);
    else passes++;
  endtask

  task automatic test_last_word();
    logic [31:0] rd, d, la;
    bit err, sb;
    int lat;
    la = (DEPTH - 1) * 4;
    d = $urandom;
    if (d == mem_a[0]) d = ~d;
    txn(0, 1'b1, la, d, rd, err, lat, sb);
    mem_a[DEPTH - 1] = d;
    checks++;
    if (err)
      $display("FAIL last_store_err got err=%b want 0", err);
    else passes++;
    txn(0, 1'b0, la, 32'h0, rd, err, lat, sb);
    checks++;
    if (rd !== d || err)
      $display("FAIL last_load got %h err=%b want %h err=0", rd, err, d);
    else passes++;
    txn(0, 1'b0, 32'h0, 32'h0, rd, err, lat, sb);
    checks++;
    if (rd !== mem_a[0] || err)
      $display("FAIL last_no_alias word0 got %h want %h", rd, mem_a[0]);
    else passes++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_basic();
    test_errors();
    test_back_to_back();
    test_lat1();
    test_rand_c();
    test_reset_mid();
    test_last_word();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
